// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: bypasses EX/MEM and MEM/WB results, stalls on unresolvable RAW hazards, and registers the operands for execute.
// Defining HAZARD_STATS_EN adds a 32-bit stall_count output that counts hazard bubbles.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_write_enable,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
`ifdef HAZARD_STATS_EN
  output logic [31:0]     stall_count,
`endif
  output logic            stall_id
);

  logic            rs1_live, rs2_live;
  logic            rs1_ex, rs2_ex, rs1_mem, rs2_mem, rs1_wb, rs2_wb;
  logic            hazard;
  logic [XLEN-1:0] rs1_resolved, rs2_resolved;

  // x0 is hardwired, so a source reading it can never match any stage.
  assign rs1_live = id_use_rs1 && (id_rs1 != 5'd0);
  assign rs2_live = id_use_rs2 && (id_rs2 != 5'd0);

  assign rs1_ex  = rs1_live && ex_valid && ex_reg_write && (ex_rd == id_rs1);
  assign rs2_ex  = rs2_live && ex_valid && ex_reg_write && (ex_rd == id_rs2);
  assign rs1_mem = rs1_live && mem_valid && mem_reg_write && (mem_rd == id_rs1);
  assign rs2_mem = rs2_live && mem_valid && mem_reg_write && (mem_rd == id_rs2);
  assign rs1_wb  = rs1_live && wb_write_enable && (wb_rd == id_rs1);
  assign rs2_wb  = rs2_live && wb_write_enable && (wb_rd == id_rs2);

  assign hazard = id_valid &&
                  (rs1_ex || rs2_ex || (rs1_mem && mem_is_load) || (rs2_mem && mem_is_load));

  // The youngest producer wins; a load in EX/MEM has no data yet and is covered by the stall.
  always_comb begin
    rs1_resolved = rf_rs1_data;
    rs2_resolved = rf_rs2_data;
    if (rs1_mem && !mem_is_load) rs1_resolved = mem_result;
    else if (rs1_wb)             rs1_resolved = wb_data;
    if (rs2_mem && !mem_is_load) rs2_resolved = mem_result;
    else if (rs2_wb)             rs2_resolved = wb_data;
  end

  assign stall_id = !reset && !flush && (hazard || ex_hold);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rd        <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (ex_hold) begin
      ex_valid     <= ex_valid;
    end else if (hazard) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_data  <= rs1_resolved;
      ex_rs2_data  <= rs2_resolved;
      ex_rd        <= id_rd;
      ex_reg_write <= id_valid && id_reg_write;
      ex_is_load   <= id_valid && id_is_load;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                stall_count <= 32'd0;
    else if (hazard && !flush) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        mem_valid, mem_reg_write, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_hold, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, stall_id;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  id_ex_operand_stage #(.XLEN(32), .PC_W(32)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_write_enable(wb_write_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_hold(ex_hold), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
`ifdef HAZARD_STATS_EN
    .stall_count(stall_count),
`endif
    .stall_id(stall_id)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_is_load = 0;
    rf_rs1_data = 0; rf_rs2_data = 0;
    mem_valid = 0; mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_write_enable = 0; wb_rd = 0; wb_data = 0;
    ex_hold = 0; flush = 0;
  endtask

  // Puts an instruction writing rd into ID/EX, with no sources read.
  task automatic load_producer(input logic [4:0] rd, input logic is_load);
    clear_inputs();
    id_valid = 1; id_rd = rd; id_reg_write = 1; id_is_load = is_load;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; ex_hold = 1;
    #3;
    checks++;
    if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd, ex_reg_write, ex_is_load} !== '0) begin
      errors++; $display("FAIL reset_regs: valid=%0b pc=%h rs1=%h rs2=%h rd=%0d", ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd);
    end
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_id); end
    tick(); tick();
    ex_hold = 0; reset = 0;
    tick();
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 5; id_rs2 = 6; id_rd = 9;
    id_use_rs1 = 1; id_use_rs2 = 1; id_reg_write = 1;
    rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL nohaz_stall: got %0b want 0", stall_id); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'h22 || ex_pc !== 32'h100 || ex_rd !== 5'd9)
    begin
      errors++; $display("FAIL nohaz_capture: valid=%0b rs1=%h rs2=%h pc=%h rd=%0d want 1/11/22/100/9",
                         ex_valid, ex_rs1_data, ex_rs2_data, ex_pc, ex_rd);
    end
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL nohaz_stall_after: got %0b want 0", stall_id); end
  endtask

  task automatic test_wb_bypass();
    clear_inputs();
    tick();
    id_valid = 1; id_rs1 = 5; id_rs2 = 6; id_rd = 10; id_use_rs1 = 1; id_use_rs2 = 1;
    rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
    wb_write_enable = 1; wb_rd = 5; wb_data = 32'hAAAA0000;
    mem_valid = 1; mem_reg_write = 1; mem_is_load = 0; mem_rd = 5; mem_result = 32'hBBBB;
    tick();
    checks++;
    if (ex_rs1_data !== 32'hBBBB || ex_rs2_data !== 32'h22) begin
      errors++; $display("FAIL bypass_mem_wins: rs1=%h rs2=%h want 0000bbbb/00000022", ex_rs1_data, ex_rs2_data);
    end
    mem_reg_write = 0;
    tick();
    checks++;
    if (ex_rs1_data !== 32'hAAAA0000) begin
      errors++; $display("FAIL bypass_wb: rs1=%h want aaaa0000", ex_rs1_data);
    end
  endtask

  task automatic test_alu_use();
    load_producer(5'd7, 1'b0);
    id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; id_rd = 11; id_reg_write = 1; id_pc = 32'h140;
    rf_rs1_data = 32'h1;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin errors++; $display("FAIL alu_stall_c1: got %0b want 1", stall_id); end
    tick();
    mem_valid = 1; mem_rd = 7; mem_reg_write = 1; mem_is_load = 0; mem_result = 32'h777;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || stall_id !== 1'b0) begin
      errors++; $display("FAIL alu_bubble: valid=%0b regw=%0b stall=%0b want 0/0/0", ex_valid, ex_reg_write, stall_id);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h777 || ex_rd !== 5'd11) begin
      errors++; $display("FAIL alu_consumer: valid=%0b rs1=%h rd=%0d want 1/777/11", ex_valid, ex_rs1_data, ex_rd);
    end
  endtask

  task automatic test_load_use();
    load_producer(5'd8, 1'b1);
    id_valid = 1; id_rs2 = 8; id_use_rs2 = 1; id_rd = 12; id_reg_write = 1;
    rf_rs2_data = 32'h5;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin errors++; $display("FAIL load_stall_c1: got %0b want 1", stall_id); end
    tick();
    mem_valid = 1; mem_rd = 8; mem_reg_write = 1; mem_is_load = 1; mem_result = 32'h999;
    #1;
    checks++;
    if (stall_id !== 1'b1 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL load_stall_c2: stall=%0b valid=%0b regw=%0b want 1/0/0", stall_id, ex_valid, ex_reg_write);
    end
    tick();
    mem_valid = 0; mem_reg_write = 0; mem_is_load = 0;
    wb_write_enable = 1; wb_rd = 8; wb_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall_id !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL load_stall_c3: stall=%0b valid=%0b want 0/0", stall_id, ex_valid);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs2_data !== 32'hDEADBEEF || ex_rd !== 5'd12) begin
      errors++; $display("FAIL load_consumer: valid=%0b rs2=%h rd=%0d want 1/deadbeef/12", ex_valid, ex_rs2_data, ex_rd);
    end
`ifdef HAZARD_STATS_EN
    // One ALU-use bubble plus two load-use bubbles since reset.
    checks++;
    if (stall_count !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", stall_count); end
`endif
  endtask

  task automatic test_flush_x0();
    load_producer(5'd13, 1'b0);
    id_valid = 1; id_rs1 = 13; id_use_rs1 = 1; id_rd = 14; id_reg_write = 1;
    flush = 1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", stall_id); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_kill: valid=%0b regw=%0b want 0/0", ex_valid, ex_reg_write);
    end
    load_producer(5'd0, 1'b0);
    id_valid = 1; id_rs1 = 0; id_use_rs1 = 1; id_rd = 15; rf_rs1_data = 32'h1234;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 0; mem_result = 32'hBAD;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b want 0", stall_id); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h1234) begin
      errors++; $display("FAIL x0_operand: valid=%0b rs1=%h want 1/1234", ex_valid, ex_rs1_data);
    end
  endtask

  task automatic test_hold();
    clear_inputs();
    id_valid = 1; id_pc = 32'h200; id_rs1 = 3; id_use_rs1 = 1; id_rd = 14; rf_rs1_data = 32'h55;
    tick();
    id_pc = 32'h300; rf_rs1_data = 32'h66; id_rd = 15;
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall_id !== 1'b1 || ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rs1_data !== 32'h55 || ex_rd !== 5'd14) begin
        errors++; $display("FAIL hold_c%0d: stall=%0b valid=%0b pc=%h rs1=%h rd=%0d want 1/1/200/55/14",
                           i, stall_id, ex_valid, ex_pc, ex_rs1_data, ex_rd);
      end
      tick();
    end
    ex_hold = 0;
    tick();
    checks++;
    if (ex_pc !== 32'h300 || ex_rs1_data !== 32'h66) begin
      errors++; $display("FAIL hold_release: pc=%h rs1=%h want 300/66", ex_pc, ex_rs1_data);
    end
  endtask

  task automatic test_reset_mid_stall();
    load_producer(5'd8, 1'b1);
    id_valid = 1; id_pc = 32'h400; id_rs1 = 8; id_use_rs1 = 1; id_rd = 16; id_reg_write = 1;
    rf_rs1_data = 32'h4242;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0b want 1", stall_id); end
    #1 reset = 1;
    #1;
    checks++;
    if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd, ex_reg_write, ex_is_load, stall_id} !== '0) begin
      errors++; $display("FAIL rst_mid_stall: valid=%0b pc=%h rd=%0d regw=%0b stall=%0b want all 0",
                         ex_valid, ex_pc, ex_rd, ex_reg_write, stall_id);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_stall_count: got %0d want 0", stall_count); end
`endif
    #1 reset = 0;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_post_stall: got %0b want 0", stall_id); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rs1_data !== 32'h4242 || ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL rst_post_capture: valid=%0b pc=%h rs1=%h regw=%0b want 1/400/4242/1",
                         ex_valid, ex_pc, ex_rs1_data, ex_reg_write);
    end
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_wb_bypass();
    test_alu_use();
    test_load_use();
    test_flush_x0();
    test_hold();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-side consumer of the register file's combinational rs1/rs2 read data; produces the ID/EX pipeline register that feeds execute.
- Selects final operands by bypassing from the EX/MEM and MEM/WB stages. The register file has no write-through, so the MEM/WB bypass is mandatory.
- Detects RAW hazards that cannot be bypassed, stalls fetch/decode and inserts bubbles; handles flush and downstream hold.

Parameters:
XLEN, 32, operand/result data width
PC_W, 32, program counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
id_valid  in  1  decode slot holds a real instruction
id_pc  in  PC_W  decode PC
id_rs1, id_rs2, id_rd  in  5 each  decoded register addresses
id_use_rs1, id_use_rs2  in  1 each  instruction actually reads the source
id_reg_write, id_is_load  in  1 each  decoded control
rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data
mem_valid, mem_reg_write, mem_is_load  in  1 each  EX/MEM stage control
mem_rd  in  5  EX/MEM destination
mem_result  in  XLEN  EX/MEM ALU result
wb_write_enable  in  1  MEM/WB write strobe (same signal driving the register file)
wb_rd  in  5  MEM/WB destination
wb_data  in  XLEN  MEM/WB writeback data
ex_hold  in  1  execute cannot accept; freeze ID/EX
flush  in  1  branch/jump redirect; kill decode and ID/EX contents
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  PC_W
ex_rs1_data, ex_rs2_data  out  XLEN each  resolved operands
ex_rd  out  5
ex_reg_write, ex_is_load  out  1 each
stall_id  out  1  hold PC and IF/ID register this cycle

Behaviour:
- Reset (async): ex_valid=0, ex_pc=0, operands=0, ex_rd=0, ex_reg_write=0, ex_is_load=0. stall_id is combinational: 0 while reset is asserted.
- A source matches a stage when: id_use_rsN=1, id_rsN!=0, the stage is valid/writing, and the stage's rd equals id_rsN. x0 never matches.
- Operand mux, highest priority first:
  - mem_result when matching EX/MEM with mem_is_load=0.
  - wb_data when matching MEM/WB.
  - Otherwise rf_rsN_data.
- Hazard (combinational), asserted when id_valid=1 and any used source matches either:
  - the current ID/EX contents (ex_valid & ex_reg_write): result not yet computed; or
  - EX/MEM with mem_is_load=1: load data not yet returned.
- Resulting stall lengths: ALU-use = 1 bubble; load-use = 2 bubbles.
- stall_id = hazard | ex_hold, forced 0 when flush=1.
- Rising-edge update, priority order:
  - flush: ex_valid<=0; other fields don't-care.
  - else ex_hold: all ID/EX fields retain their values.
  - else hazard: ex_valid<=0 (bubble), ex_reg_write<=0, ex_is_load<=0.
  - else: capture id_* controls and the resolved operands; ex_valid<=id_valid; ex_reg_write/ex_is_load gated by id_valid.
- A bubble never carries ex_reg_write=1.
- Latency: 1 cycle from decode to ID/EX when there is no hazard.
- Hold while a hazard is pending: operands are recomputed each cycle, so a bypass that becomes valid during the hold is picked up on release.
- Reset mid-stall: stall and bubbles abandoned; first post-reset decode captured normally.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: adds output stall_count, 32 bits, reset 0. Increments on every edge where hazard=1 and flush=0. ex_hold cycles are not counted. Wraps 0xFFFFFFFF -> 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- No hazard: id_rs1=5, id_rs2=6, rf data 0x11/0x22, no matches -> next cycle ex_valid=1, ex_rs1_data=0x11, ex_rs2_data=0x22, stall_id=0 throughout.
- WB bypass:
  - Setup: wb_write_enable=1, wb_rd=5, wb_data=0xAAAA0000, rf_rs1_data stale 0x11; EX/MEM rd=5 with mem_reg_write=1 and mem_is_load=0, mem_result=0xBBBB.
  - Response: ex_rs1_data=0xBBBB (EX/MEM wins). With mem_reg_write=0 -> ex_rs1_data=0xAAAA0000.
- ALU-use: ID/EX holds add x7 (ex_reg_write=1); decode uses x7 -> stall_id=1 for exactly 1 cycle, one bubble; consumer then captures mem_result.
- Load-use: ID/EX holds lw x8; decode uses x8 -> stall_id=1 for 2 cycles, 2 bubbles; consumer captures wb_data=0xDEADBEEF.
- Flush and x0:
  - Hazard pending plus flush=1 -> stall_id=0, ex_valid=0 next edge.
  - id_rs1=0 with ex_rd=0 and ex_reg_write=1 -> no stall.
- Hold/reset and stats:
  - ex_hold=1 for 3 cycles -> ID/EX stable, stall_id=1.
  - Async reset asserted mid-stall -> all outputs 0 immediately.
  - With HAZARD_STATS_EN, load-use scenario -> stall_count=2.
